parity_scrub_ctrl: RTL and testbench

Background scrubber and read-port arbiter for the raw hits and miniscope RAMs.
- Walks every RAM address through the shared read port and samples the per-RAM parity flags returned for each scrub read.
- Yields the read port to the sequencer whenever it requests it.
- Accumulates per-pass error count, first failing address and bad-RAM map for VME readout.
- Sits between the sequencer readout logic, the RAM read port and the parity summary logic.

---
 rtl/parity_scrub_ctrl.sv | 148 ++++++++++++++
 tb/tb_parity_scrub_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_scrub_ctrl.sv
// Background parity scrubber and read-port arbiter for the raw hits / miniscope RAMs.
// Optional build macro SCRUB_AUTO_RESTART_EN: DONE chains straight into the next pass while scrub_en=1.
module parity_scrub_ctrl #(
    parameter int RAM_ADRB   = 11,
    parameter int MXRAM      = 37,
    parameter int RD_LATENCY = 2
) (
    input  logic                clock,
    input  logic                global_reset,
    input  logic                scrub_en,
    input  logic                scrub_start,
    input  logic                seq_rd_req,
    input  logic [RAM_ADRB-1:0] seq_rd_adr,
    output logic                seq_rd_gnt,
    output logic                ram_rd_en,
    output logic [RAM_ADRB-1:0] ram_rd_adr,
    input  logic [MXRAM-1:0]    parity_err,
    output logic                scrub_busy,
    output logic                scrub_done,
    output logic [15:0]         scrub_pass_cnt,
    output logic [15:0]         scrub_err_cnt,
    output logic [RAM_ADRB-1:0] scrub_err_adr,
    output logic                scrub_err,
    output logic [MXRAM-1:0]    scrub_err_map
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    typedef struct packed {
        logic                valid;
        logic [RAM_ADRB-1:0] adr;
    } tag_t;

    localparam logic [RAM_ADRB-1:0] ADR_LAST   = '1;
    localparam logic [1:0]          DRAIN_LOAD = 2'(RD_LATENCY - 1);

    state_t                state, state_next;
    logic [RAM_ADRB-1:0]   scrub_adr;
    tag_t [RD_LATENCY-1:0] tag_pipe;
    tag_t                  tag_in, tag_out;
    logic [1:0]            drain_cnt;
    logic                  aborted;
    logic                  pass_start, scrub_issue, drain_load, abort_set, pass_done, retire;

    // Sequencer always wins the port; the scrub read simply waits in place.
    assign seq_rd_gnt = seq_rd_req;
    assign ram_rd_en  = seq_rd_req | (state == READ);
    assign ram_rd_adr = seq_rd_req ? seq_rd_adr : scrub_adr;
    assign scrub_done = (state == DONE);

    assign tag_in  = '{valid: scrub_issue, adr: scrub_adr};
    assign tag_out = tag_pipe[RD_LATENCY-1];
    assign retire  = tag_out.valid && (|parity_err);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next  = state;
        pass_start  = 1'b0;
        scrub_issue = 1'b0;
        drain_load  = 1'b0;
        abort_set   = 1'b0;
        pass_done   = 1'b0;
        case (state)
            IDLE: begin
                if (scrub_start && scrub_en) begin
                    state_next = READ;
                    pass_start = 1'b1;
                end
            end
            READ: begin
                scrub_issue = !seq_rd_req;
                if (!scrub_en) begin
                    state_next = DRAIN;
                    drain_load = 1'b1;
                    abort_set  = 1'b1;
                end else if (scrub_issue && scrub_adr == ADR_LAST) begin
                    state_next = DRAIN;
                    drain_load = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_cnt == 2'd0) state_next = aborted ? IDLE : DONE;
            end
            DONE: begin
                pass_done = 1'b1;
`ifdef SCRUB_AUTO_RESTART_EN
                if (scrub_en) begin
                    state_next = READ;
                    pass_start = 1'b1;
                end else begin
                    state_next = IDLE;
                end
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (global_reset) begin
            state          <= IDLE;
            scrub_busy     <= 1'b0;
            scrub_adr      <= '0;
            // NOTE: the tag pipe is reset so reads in flight at reset can never retire afterwards.
            tag_pipe       <= '0;
            drain_cnt      <= '0;
            aborted        <= 1'b0;
            scrub_pass_cnt <= '0;
            scrub_err_cnt  <= '0;
            scrub_err_adr  <= '0;
            scrub_err      <= 1'b0;
            scrub_err_map  <= '0;
        end else begin
            state      <= state_next;
            scrub_busy <= (state_next != IDLE);

            for (int i = RD_LATENCY - 1; i > 0; i--) tag_pipe[i] <= tag_pipe[i-1];
            tag_pipe[0] <= tag_in;

            if (pass_start)                                scrub_adr <= '0;
            else if (scrub_issue && scrub_adr != ADR_LAST) scrub_adr <= scrub_adr + RAM_ADRB'(1);

            if (drain_load)                              drain_cnt <= DRAIN_LOAD;
            else if (state == DRAIN && drain_cnt != 2'd0) drain_cnt <= drain_cnt - 2'd1;

            if (abort_set)       aborted <= 1'b1;
            else if (pass_start) aborted <= 1'b0;

            if (pass_done && scrub_pass_cnt != 16'hFFFF) scrub_pass_cnt <= scrub_pass_cnt + 16'd1;

            // Per-pass results hold until the next pass begins.
            if (pass_start) begin
                scrub_err_cnt <= '0;
                scrub_err_adr <= '0;
                scrub_err     <= 1'b0;
                scrub_err_map <= '0;
            end else if (retire) begin
                if (scrub_err_cnt != 16'hFFFF) scrub_err_cnt <= scrub_err_cnt + 16'd1;
                if (!scrub_err) scrub_err_adr <= tag_out.adr;
                scrub_err     <= 1'b1;
                scrub_err_map <= scrub_err_map | parity_err;
            end
        end
    end

endmodule

// File: tb/tb_parity_scrub_ctrl.sv
// Scoreboard bench for parity_scrub_ctrl: queued expected reads and pass results, popped by a monitor.
module tb_parity_scrub_ctrl;
    localparam int ADRB = 4;
    localparam int MX   = 37;
    localparam int LAT  = 2;

    logic            clock = 1'b0;
    logic            global_reset, scrub_en, scrub_start, seq_rd_req;
    logic [ADRB-1:0] seq_rd_adr;
    logic            seq_rd_gnt, ram_rd_en;
    logic [ADRB-1:0] ram_rd_adr;
    logic [MX-1:0]   parity_err;
    logic            scrub_busy, scrub_done, scrub_err;
    logic [15:0]     scrub_pass_cnt, scrub_err_cnt;
    logic [ADRB-1:0] scrub_err_adr;
    logic [MX-1:0]   scrub_err_map;

    always #5 clock = ~clock;

    parity_scrub_ctrl #(.RAM_ADRB(ADRB), .MXRAM(MX), .RD_LATENCY(LAT)) dut (
        .clock          (clock),
        .global_reset   (global_reset),
        .scrub_en       (scrub_en),
        .scrub_start    (scrub_start),
        .seq_rd_req     (seq_rd_req),
        .seq_rd_adr     (seq_rd_adr),
        .seq_rd_gnt     (seq_rd_gnt),
        .ram_rd_en      (ram_rd_en),
        .ram_rd_adr     (ram_rd_adr),
        .parity_err     (parity_err),
        .scrub_busy     (scrub_busy),
        .scrub_done     (scrub_done),
        .scrub_pass_cnt (scrub_pass_cnt),
        .scrub_err_cnt  (scrub_err_cnt),
        .scrub_err_adr  (scrub_err_adr),
        .scrub_err      (scrub_err),
        .scrub_err_map  (scrub_err_map)
    );

    typedef struct packed {
        logic            gnt;
        logic [ADRB-1:0] adr;
    } rd_exp_t;

    typedef struct packed {
        logic [15:0]     cnt;
        logic [ADRB-1:0] adr;
        logic [MX-1:0]   map;
        logic            err;
        logic [15:0]     pass;
    } done_exp_t;

    rd_exp_t   rd_q[$];
    done_exp_t done_q[$];
    rd_exp_t   rd_e;
    done_exp_t done_e;
    int        checks  = 0;
    int        errors  = 0;
    int        pass_clk = 0;

    // RAM model: per-address parity flags, returned LAT clocks after the read.
    logic [MX-1:0] err_mem [1<<ADRB];
    logic [MX-1:0] seq_inject = '0;
    logic [MX-1:0] ret0 = '0;
    logic [MX-1:0] ret1 = '0;

    always @(posedge clock) begin
        ret0 <= !ram_rd_en ? '0 : (seq_rd_req ? seq_inject : err_mem[ram_rd_adr]);
        ret1 <= ret0;
        pass_clk <= pass_clk + 1;
    end
    assign parity_err = ret1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every read and every done pulse must match the next queued expectation.
    always @(negedge clock) begin
        if (!global_reset) begin
            if (ram_rd_en) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_extra actual adr=%0h gnt=%0b required no read", ram_rd_adr, seq_rd_gnt);
                end else begin
                    rd_e = rd_q.pop_front();
                    check("rd_adr", 64'(ram_rd_adr), 64'(rd_e.adr));
                    check("rd_gnt", 64'(seq_rd_gnt), 64'(rd_e.gnt));
                end
            end
            if (scrub_done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_extra actual scrub_done=1 required 0");
                end else begin
                    done_e = done_q.pop_front();
                    check("done_err_cnt",  64'(scrub_err_cnt),  64'(done_e.cnt));
                    check("done_err_adr",  64'(scrub_err_adr),  64'(done_e.adr));
                    check("done_err_map",  64'(scrub_err_map),  64'(done_e.map));
                    check("done_err",      64'(scrub_err),      64'(done_e.err));
                    check("done_pass_cnt", 64'(scrub_pass_cnt), 64'(done_e.pass));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_scrub(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) rd_q.push_back('{gnt: 1'b0, adr: ADRB'(a)});
    endtask

    task automatic push_done(input int cnt, input int adr, input logic [MX-1:0] map,
                             input logic err, input int pass);
        done_q.push_back('{cnt: 16'(cnt), adr: ADRB'(adr), map: map, err: err, pass: 16'(pass)});
    endtask

    task automatic pulse_start();
        scrub_start = 1'b1;
        pass_clk    = 0;
        tick(1);
        scrub_start = 1'b0;
    endtask

    // Waits (bounded) for scrub_done; pass_clk counts clocks from the start pulse cycle.
    task automatic wait_done(input string name, input int exp_clk);
        int guard = 0;
        while (scrub_done !== 1'b1 && guard < 500) begin
            tick(1);
            guard++;
        end
        check(name, 64'(pass_clk), 64'(exp_clk));
    endtask

    task automatic end_pass();
        scrub_en = 1'b0;
        tick(1);
        scrub_en = 1'b1;
    endtask

    task automatic clear_mem();
        for (int a = 0; a < (1 << ADRB); a++) err_mem[a] = '0;
    endtask

    initial begin
        int n;
        global_reset = 1'b1;
        scrub_en     = 1'b1;
        scrub_start  = 1'b0;
        seq_rd_req   = 1'b0;
        seq_rd_adr   = '0;
        clear_mem();
        tick(3);
        global_reset = 1'b0;

        @(negedge clock);
        check("rst_busy",     64'(scrub_busy),     64'd0);
        check("rst_done",     64'(scrub_done),     64'd0);
        check("rst_pass_cnt", 64'(scrub_pass_cnt), 64'd0);
        check("rst_err_cnt",  64'(scrub_err_cnt),  64'd0);
        check("rst_err_adr",  64'(scrub_err_adr),  64'd0);
        check("rst_err",      64'(scrub_err),      64'd0);
        check("rst_err_map",  64'(scrub_err_map),  64'd0);
        check("rst_rd_en",    64'(ram_rd_en),      64'd0);
        tick(1);

        // scrub_start with scrub_en low must not start a pass
        scrub_en = 1'b0;
        pulse_start();
        tick(1);
        check("start_no_en_busy", 64'(scrub_busy), 64'd0);
        scrub_en = 1'b1;

        // Clean pass: 16 reads, done 16+2+1 clocks after start
        push_scrub(0, 15);
        push_done(0, 0, '0, 1'b0, 0);
        pulse_start();
        wait_done("t1_done_latency", 19);
        end_pass();
        check("t1_pass_cnt", 64'(scrub_pass_cnt), 64'd1);
        check("t1_busy",     64'(scrub_busy),     64'd0);
        check("t1_err",      64'(scrub_err),      64'd0);
        check("t1_rd_left",  64'(rd_q.size()),    64'd0);

        // Two failing addresses; a mid-pass start pulse must be ignored
        err_mem[5] = 37'h00_8000_0000;
        err_mem[9] = 37'h00_0000_0004;
        push_scrub(0, 15);
        push_done(2, 5, 37'h00_8000_0004, 1'b1, 1);
        pulse_start();
        tick(3);
        scrub_start = 1'b1;
        tick(1);
        scrub_start = 1'b0;
        wait_done("t2_done_latency", 19);
        end_pass();
        check("t2_err_cnt",  64'(scrub_err_cnt),  64'd2);
        check("t2_err_adr",  64'(scrub_err_adr),  64'd5);
        check("t2_err_map",  64'(scrub_err_map),  64'h00_8000_0004);
        check("t2_pass_cnt", 64'(scrub_pass_cnt), 64'd2);
        clear_mem();

        // Sequencer steals 3 clocks at scrub_adr=7; its parity returns are ignored
        seq_inject = '1;
        push_scrub(0, 6);
        for (int i = 0; i < 3; i++) rd_q.push_back('{gnt: 1'b1, adr: 4'hA});
        push_scrub(7, 15);
        push_done(0, 0, '0, 1'b0, 2);
        pulse_start();
        repeat (7) @(posedge clock);
        #1;
        seq_rd_req = 1'b1;
        seq_rd_adr = 4'hA;
        tick(3);
        seq_rd_req = 1'b0;
        wait_done("t3_done_latency", 22);
        end_pass();
        check("t3_err_cnt",  64'(scrub_err_cnt),  64'd0);
        check("t3_err",      64'(scrub_err),      64'd0);
        check("t3_pass_cnt", 64'(scrub_pass_cnt), 64'd3);
        check("t3_rd_left",  64'(rd_q.size()),    64'd0);
        seq_inject = '0;

        // Abort at scrub_adr=10: one last read, 2-clock drain, no done, errors kept
        err_mem[9]  = 37'h01_0000_0000;
        err_mem[10] = 37'h10_0000_0000;
        push_scrub(0, 10);
        pulse_start();
        repeat (10) @(posedge clock);
        #1;
        scrub_en = 1'b0;
        n = 0;
        while (scrub_busy && n < 20) begin
            tick(1);
            n++;
        end
        check("t4_abort_drain", 64'(n),              64'd3);
        check("t4_err_cnt",     64'(scrub_err_cnt),  64'd2);
        check("t4_err_adr",     64'(scrub_err_adr),  64'd9);
        check("t4_err_map",     64'(scrub_err_map),  64'h11_0000_0000);
        check("t4_pass_cnt",    64'(scrub_pass_cnt), 64'd3);
        tick(3);
        check("t4_err_hold",    64'(scrub_err),      64'd1);
        check("t4_rd_left",     64'(rd_q.size()),    64'd0);
        scrub_en = 1'b1;
        clear_mem();

        // Reset mid-READ with reads in flight whose errors return after reset
        err_mem[2] = 37'h1;
        err_mem[3] = 37'h2;
        err_mem[4] = 37'h4;
        push_scrub(0, 4);
        pulse_start();
        repeat (5) @(posedge clock);
        #1;
        global_reset = 1'b1;
        tick(1);
        check("t5_busy",     64'(scrub_busy),     64'd0);
        check("t5_err_cnt",  64'(scrub_err_cnt),  64'd0);
        check("t5_pass_cnt", 64'(scrub_pass_cnt), 64'd0);
        check("t5_rd_en",    64'(ram_rd_en),      64'd0);
        global_reset = 1'b0;
        tick(4);
        check("t5_err_late", 64'(scrub_err_cnt),  64'd0);
        check("t5_err",      64'(scrub_err),      64'd0);
        check("t5_err_map",  64'(scrub_err_map),  64'd0);
        check("t5_rd_left",  64'(rd_q.size()),    64'd0);
        clear_mem();

`ifdef SCRUB_AUTO_RESTART_EN
        // Three chained passes; the first has an error that must clear at restart
        err_mem[5] = 37'h1;
        push_scrub(0, 15);
        push_scrub(0, 15);
        push_scrub(0, 15);
        push_done(1, 5, 37'h1, 1'b1, 0);
        push_done(0, 0, '0, 1'b0, 1);
        push_done(0, 0, '0, 1'b0, 2);
        pulse_start();
        wait_done("t6_pass1", 19);
        err_mem[5] = '0;
        pass_clk = 0;
        tick(1);
        check("t6_no_idle1", 64'(scrub_busy), 64'd1);
        wait_done("t6_pass2", 19);
        pass_clk = 0;
        tick(1);
        check("t6_no_idle2", 64'(scrub_busy), 64'd1);
        wait_done("t6_pass3", 19);
        end_pass();
        check("t6_pass_cnt", 64'(scrub_pass_cnt), 64'd3);
        check("t6_busy",     64'(scrub_busy),     64'd0);
`else
        // Without auto-restart nothing runs until another scrub_start
        tick(5);
        check("t6_stays_idle", 64'(scrub_busy), 64'd0);
`endif

        check("end_rd_left",   64'(rd_q.size()),   64'd0);
        check("end_done_left", 64'(done_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
